// File: rtl/fp_addsub_sched.sv
// Shares one FpCustomAddSub pipeline between NumReq requesters with per-requester handshakes.
// Define FP_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins priority; the default is round-robin.
module fp_addsub_sched #(
    parameter int unsigned NumReq      = 4,
    parameter int unsigned ManWidth    = 16,
    parameter int unsigned ExpWidth    = 6,
    parameter int unsigned UnitLatency = 5,
    parameter int unsigned TagDepth    = 8,
    localparam int unsigned W          = 1 + ExpWidth + ManWidth
) (
    input  logic                  Clk_i,
    input  logic                  Rst_i,
    input  logic [NumReq-1:0]     ReqValid_i,
    input  logic [NumReq*W-1:0]   ReqA_i,
    input  logic [NumReq*W-1:0]   ReqB_i,
    input  logic [NumReq-1:0]     ReqAddSub_i,
    output logic [NumReq-1:0]     ReqReady_o,
    output logic [W-1:0]          UnitA_o,
    output logic [W-1:0]          UnitB_o,
    output logic                  UnitAddSub_o,
    output logic                  UnitNd_o,
    input  logic [W-1:0]          UnitResult_i,
    input  logic                  UnitResultValid_i,
    output logic [W-1:0]          Result_o,
    output logic [NumReq-1:0]     ResultValid_o,
    output logic                  Busy_o,
    output logic                  TagErr_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned TagW = (TagDepth > 1) ? $clog2(TagDepth) : 1;
    localparam int unsigned CntW = $clog2(TagDepth + 1);
    localparam int unsigned FlW  = (UnitLatency > 0) ? $clog2(UnitLatency + 1) : 1;

    typedef enum logic [0:0] {StFlush, StRun} state_e;

    state_e             state_q, state_d;
    logic [FlW-1:0]     flush_cnt_q, flush_cnt_d;

    logic [IdxW-1:0]    tag_mem [TagDepth];
    logic [TagW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]    count_q, count_d;

    logic [W-1:0]       unit_a_q, unit_b_q;
    logic               unit_op_q, unit_nd_q;
    logic [W-1:0]       result_q;
    logic [NumReq-1:0]  result_valid_q;
    logic               tag_err_q;

    logic               run, fifo_full, fifo_empty;
    logic               pop_req, pop, push, can_grant;
    logic               grant_found;
    logic [IdxW-1:0]    grant_idx, cand;
    logic [IdxW-1:0]    pop_tag;
    logic [NumReq-1:0]  pop_onehot;

    // ------------------------------------------------------------------
    // Flush / run control
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q == StFlush) begin
            if (flush_cnt_q == FlW'(UnitLatency)) begin
                state_d = StRun;
            end else begin
                flush_cnt_d = flush_cnt_q + FlW'(1);
            end
        end
    end

    assign run        = (state_q == StRun);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(TagDepth));

    // Results reaching the unit output during FLUSH are stale and must not touch the FIFO.
    assign pop_req   = run && UnitResultValid_i;
    assign pop       = pop_req && !fifo_empty;
    assign can_grant = run && (!fifo_full || pop);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef FP_SCHED_FIXED_PRIO_EN
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = IdxW'(i);
            if (!grant_found && ReqValid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        if (!can_grant) begin
            grant_found = 1'b0;
        end
    end
`else
    logic [IdxW-1:0]    ptr_q;
    int unsigned        rr_idx;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        rr_idx      = 0;
        // Search starts just past the last winner so every requester gets a turn.
        for (int unsigned k = 1; k <= NumReq; k++) begin
            rr_idx = (32'(ptr_q) + k) % NumReq;
            cand   = IdxW'(rr_idx);
            if (!grant_found && ReqValid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        if (!can_grant) begin
            grant_found = 1'b0;
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            ptr_q <= IdxW'(NumReq - 1);
        end else if (push) begin
            ptr_q <= grant_idx;
        end
    end
`endif

    assign push = grant_found;

    always_comb begin
        ReqReady_o = '0;
        if (push) begin
            ReqReady_o[grant_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Tag FIFO
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    assign pop_tag = tag_mem[rd_ptr_q];

    always_comb begin
        pop_onehot          = '0;
        pop_onehot[pop_tag] = 1'b1;
    end

    always_ff @(posedge Clk_i) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= grant_idx;
        end
    end

    // ------------------------------------------------------------------
    // State, operand and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            state_q        <= StFlush;
            flush_cnt_q    <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            unit_a_q       <= '0;
            unit_b_q       <= '0;
            unit_op_q      <= 1'b0;
            unit_nd_q      <= 1'b0;
            result_q       <= '0;
            result_valid_q <= '0;
            tag_err_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            count_q     <= count_d;
            unit_nd_q   <= push;
            if (push) begin
                unit_a_q  <= ReqA_i[32'(grant_idx)*W +: W];
                unit_b_q  <= ReqB_i[32'(grant_idx)*W +: W];
                unit_op_q <= ReqAddSub_i[grant_idx];
                wr_ptr_q  <= wr_ptr_q + TagW'(1);
            end
            if (pop) begin
                rd_ptr_q       <= rd_ptr_q + TagW'(1);
                result_q       <= UnitResult_i;
                result_valid_q <= pop_onehot;
            end else begin
                result_valid_q <= '0;
            end
            if (pop_req && fifo_empty) begin
                tag_err_q <= 1'b1;
            end
        end
    end

    assign UnitA_o       = unit_a_q;
    assign UnitB_o       = unit_b_q;
    assign UnitAddSub_o  = unit_op_q;
    assign UnitNd_o      = unit_nd_q;
    assign Result_o      = result_q;
    assign ResultValid_o = result_valid_q;
    assign TagErr_o      = tag_err_q;
    assign Busy_o        = (state_q == StFlush) || !fifo_empty || unit_nd_q;

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Bench for fp_addsub_sched: grant table, hand sequences for latency/full/tag-error/reset,
// and randomized traffic against a queue-based reference model with a behavioural unit.
module tb_fp_addsub_sched;

    localparam int N = 4;
    localparam int L = 5;
    localparam int D = 8;
    localparam int W = 23;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic [N-1:0]     req_op = '0;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     unit_a, unit_b;
    logic             unit_op, unit_nd;
    logic [W-1:0]     unit_res = '0;
    logic             unit_res_valid = 1'b0;
    logic [W-1:0]     result;
    logic [N-1:0]     result_valid;
    logic             busy, tag_err;

    fp_addsub_sched #(
        .NumReq(N), .ManWidth(16), .ExpWidth(6), .UnitLatency(L), .TagDepth(D)
    ) dut (
        .Clk_i            (clk),
        .Rst_i            (rst),
        .ReqValid_i       (req_valid),
        .ReqA_i           (req_a),
        .ReqB_i           (req_b),
        .ReqAddSub_i      (req_op),
        .ReqReady_o       (req_ready),
        .UnitA_o          (unit_a),
        .UnitB_o          (unit_b),
        .UnitAddSub_o     (unit_op),
        .UnitNd_o         (unit_nd),
        .UnitResult_i     (unit_res),
        .UnitResultValid_i(unit_res_valid),
        .Result_o         (result),
        .ResultValid_o    (result_valid),
        .Busy_o           (busy),
        .TagErr_o         (tag_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int since = 0;
    bit hold = 0;
    bit inj = 0;
    bit strict = 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Stand-in for the arithmetic: any fixed, operand-order-sensitive function will do.
    function automatic logic [W-1:0] unit_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic op);
        logic [W-1:0] bs;
        bs = b << 1;
        return (a ^ bs) + W'(op);
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int p);
`ifdef FP_SCHED_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
`endif
        return -1;
    endfunction

    // Behavioural unit: fixed latency, never resets, can be stalled by the bench.
    typedef struct {logic [W-1:0] d; int due;} ures_t;
    ures_t uq[$];

    always @(posedge clk) begin
        cyc++;
        if (rst) since = 0; else since++;
        #1;
        unit_res_valid = 1'b0;
        if (inj) begin
            unit_res_valid = 1'b1;
            unit_res = W'($urandom);
        end else if (!hold && uq.size() > 0 && uq[0].due <= cyc) begin
            unit_res_valid = 1'b1;
            unit_res = uq[0].d;
            void'(uq.pop_front());
        end
    end

    always @(negedge clk) begin
        if (unit_nd === 1'b1) uq.push_back('{unit_fn(unit_a, unit_b, unit_op), cyc + L});
    end

    // Reference model: issue order queue of {owner, result, due cycle}.
    typedef struct {int owner; logic [W-1:0] d; int due;} sb_t;
    sb_t sbq[$];
    int  mcount = 0;
    int  mptr = N - 1;
    bit  mtagerr = 0;

    always @(negedge clk) begin
        logic [N-1:0] er;
        bit mrun, popn, expect_res;
        int g;
        if (rst) begin
            mcount = 0;
            sbq.delete();
            mptr = N - 1;
            mtagerr = 0;
        end else begin
            mrun = (since >= L + 1);
            check("tag_err_track", tag_err, mtagerr);
            expect_res = 0;
            if (sbq.size() > 0) expect_res = strict ? (sbq[0].due <= cyc) : (result_valid != 0);
            if (expect_res) begin
                check("result_owner", result_valid, N'(1) << sbq[0].owner);
                check("result_data", result, sbq[0].d);
                void'(sbq.pop_front());
            end else if (result_valid !== '0) begin
                check("result_spurious", result_valid, 0);
            end
            popn = mrun && unit_res_valid && mcount > 0;
            if (mrun && unit_res_valid && mcount == 0) mtagerr = 1;
            er = '0;
            g = -1;
            if (mrun && (mcount < D || popn)) g = pick(req_valid, mptr);
            if (g >= 0) er[g] = 1'b1;
            check("ready", req_ready, er);
            if (g >= 0) begin
                mptr = g;
                sbq.push_back('{g, unit_fn(req_a[g*W +: W], req_b[g*W +: W], req_op[g]),
                                cyc + 2 + L});
                mcount++;
            end
            if (popn) mcount--;
        end
    end

    task automatic rand_operands();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'($urandom);
            req_b[i*W +: W] = W'($urandom);
            req_op[i] = 1'($urandom);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {logic [N-1:0] v; logic [N-1:0] g;} vec_t;
    vec_t tbl[14];

    initial begin
        int t, grants;
        logic [N-1:0] eg;
        tbl = '{'{4'b1111, 4'b0001}, '{4'b1111, 4'b0010}, '{4'b1111, 4'b0100},
                '{4'b1111, 4'b1000}, '{4'b1111, 4'b0001}, '{4'b0101, 4'b0100},
                '{4'b0101, 4'b0001}, '{4'b0101, 4'b0100}, '{4'b0101, 4'b0001},
                '{4'b0010, 4'b0010}, '{4'b0000, 4'b0000}, '{4'b1000, 4'b1000},
                '{4'b1001, 4'b0001}, '{4'b1001, 4'b1000}};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_nd", unit_nd, 0);
        check("rst_rvalid", result_valid, 0);
        check("rst_result", result, 0);
        check("rst_unit_a", unit_a, 0);
        check("rst_unit_b", unit_b, 0);
        check("rst_unit_op", unit_op, 0);
        check("rst_tag_err", tag_err, 0);
        check("rst_busy", busy, 1);

        // All valid from cycle 0: six silent FLUSH cycles, then the grant table.
        next_cycle();
        rst = 1'b0;
        req_valid = '1;
        rand_operands();
        for (int c = 0; c <= L; c++) begin
            @(negedge clk);
            check("flush_ready", req_ready, 0);
            next_cycle();
        end
        for (int e = 0; e < 14; e++) begin
            req_valid = tbl[e].v;
            rand_operands();
            eg = tbl[e].g;
`ifdef FP_SCHED_FIXED_PRIO_EN
            eg = tbl[e].v & (~tbl[e].v + 1'b1);
`endif
            @(negedge clk);
            check("table_grant", req_ready, eg);
            next_cycle();
        end
        req_valid = '0;
        repeat (12) next_cycle();

        // Single request from requester 1: exact operand and result latency.
        req_valid = 4'b0010;
        req_a[1*W +: W] = 23'h1A2B3C;
        req_b[1*W +: W] = '0;
        req_op[1] = 1'b0;
        t = cyc;
        @(negedge clk);
        check("single_ready", req_ready, 4'b0010);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("single_nd", unit_nd, 1);
        check("single_a", unit_a, 23'h1A2B3C);
        check("single_b", unit_b, 0);
        check("single_op", unit_op, 0);
        while (cyc < t + 6) @(negedge clk);
        check("single_early", result_valid, 0);
        @(negedge clk);
        check("single_cycle", cyc, t + 7);
        check("single_rvalid", result_valid, 4'b0010);
        check("single_result", result, 23'h1A2B3C);
        repeat (4) next_cycle();

        // Stall the unit: FIFO fills at TagDepth, then push/pop at full.
        @(negedge clk);
        hold = 1;
        strict = 0;
        next_cycle();
        req_valid = '1;
        grants = 0;
        for (int c = 0; c < 12; c++) begin
            rand_operands();
            @(negedge clk);
            if (req_ready != 0) grants++;
            next_cycle();
        end
        @(negedge clk);
        check("full_grants", grants, D);
        check("full_ready", req_ready, 0);
        check("full_busy", busy, 1);
        hold = 0;
        next_cycle();
        grants = 0;
        for (int c = 0; c < 4; c++) begin
            rand_operands();
            @(negedge clk);
            if (req_ready != 0) grants++;
            next_cycle();
        end
        check("full_pushpop", grants, 4);
        req_valid = '0;
        for (int c = 0; c < 40 && sbq.size() > 0; c++) next_cycle();
        check("full_drain", sbq.size(), 0);
        strict = 1;
        repeat (3) next_cycle();

        // Result with an empty FIFO.
        @(negedge clk);
        inj = 1;
        @(negedge clk);
        inj = 0;
        @(negedge clk);
        check("tagerr_set", tag_err, 1);
        check("tagerr_rvalid", result_valid, 0);
        repeat (5) @(negedge clk);
        check("tagerr_sticky", tag_err, 1);

        // Reset with three operations in flight.
        next_cycle();
        req_valid = '1;
        repeat (3) begin
            rand_operands();
            next_cycle();
        end
        req_valid = '0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c <= L; c++) begin
            @(negedge clk);
            check("mid_rst_busy", busy, 1);
            check("mid_rst_rvalid", result_valid, 0);
            check("mid_rst_tag_err", tag_err, 0);
            next_cycle();
        end
        @(negedge clk);
        check("mid_rst_idle", busy, 0);
        check("mid_rst_tag_err_end", tag_err, 0);
        next_cycle();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom);
            rand_operands();
            next_cycle();
        end
        req_valid = '0;
        repeat (15) next_cycle();
        check("rand_drain", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
